// File: rtl/freq_div_ctrl.sv
// ---------------------------------------------------------------------------
// freq_div_ctrl
//
// Programmable clock-enable style frequency divider. A divide ratio N is
// written through a valid/ready port, and the block produces a divided
// square wave with floor(N/2) high cycles per N-cycle period. It also
// produces a one-cycle tick at the start of every period. Ratio changes made
// while dividing are staged and only take effect at a period boundary, so
// the output never shows a truncated or stretched period. A stop request
// lets the current period finish before the block returns to idle.
//
// Ports
//   clock      : single clock, all state changes on its rising edge
//   rst        : asynchronous active-low reset
//   cfg_valid  : divide-ratio write request
//   cfg_div    : requested divide ratio N (unsigned, WIDTH bits)
//   cfg_ready  : controller can accept cfg_div this cycle
//   start      : level request to begin or resume dividing
//   stop       : level request to end dividing at the next period boundary
//   div_out    : registered divided output
//   tick       : registered pulse on the first cycle of each div_out period
//   busy       : high whenever the controller is not idle
//   err        : registered pulse on a rejected ratio or a rejected start
// ---------------------------------------------------------------------------
module freq_div_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             cfg_ready,
   input  logic             start,
   input  logic             stop,
   output logic             div_out,
   output logic             tick,
   output logic             busy,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] activeDiv_q, activeDiv_d;
   logic [WIDTH-1:0] pendDiv_q, pendDiv_d;
   logic             pendVld_q, pendVld_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             divOut_q, divOut_d;
   logic             tick_q, tick_d;
   logic             err_q, err_d;

   logic             cfgAccept;
   logic             cfgBad;
   logic             wrap;

   // Handshake and period-boundary decode. While idle a write always lands
   // straight in the active ratio, so the port is always open; while
   // dividing only one staged ratio can be held, so the port closes until
   // that staged ratio has been consumed at a wrap.
   assign cfg_ready = (state_q == IDLE) || !pendVld_q;
   assign cfgAccept = cfg_valid && cfg_ready;
   assign cfgBad    = cfgAccept && (cfg_div < WIDTH'(2));
   assign wrap      = (state_q != IDLE) && (cnt_q == (activeDiv_q - WIDTH'(1)));

   assign busy      = (state_q != IDLE);
   assign div_out   = divOut_q;
   assign tick      = tick_q;
   assign err       = err_q;

   // Next-state computation for the controller. The outputs div_out and
   // tick are derived from the next counter and ratio values so that, once
   // registered, they line up with the counter in the same cycle: the first
   // RUN cycle shows cnt=0 together with div_out=1 and tick=1.
   // In STOPPING a fresh start wins over the wrap, so a resume requested
   // exactly on the boundary keeps the waveform going instead of dropping to
   // idle. A good write accepted on the final wrap into IDLE goes straight to
   // the active ratio, because no later wrap would ever promote it.
   always_comb begin
      state_d     = state_q;
      activeDiv_d = activeDiv_q;
      pendDiv_d   = pendDiv_q;
      pendVld_d   = pendVld_q;
      cnt_d       = cnt_q;
      err_d       = cfgBad;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (cfgAccept && !cfgBad) begin
               activeDiv_d = cfg_div;
            end
            if (start && !stop) begin
               if (activeDiv_q >= WIDTH'(2)) begin
                  state_d = RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         RUN, STOPPING: begin
            cnt_d = wrap ? '0 : (cnt_q + WIDTH'(1));

            if (state_q == RUN) begin
               if (stop) begin
                  state_d = STOPPING;
               end
            end else if (start && !stop) begin
               state_d = RUN;
            end else if (wrap) begin
               state_d = IDLE;
            end

            if (wrap && pendVld_q) begin
               activeDiv_d = pendDiv_q;
               pendVld_d   = 1'b0;
            end

            if (cfgAccept && !cfgBad) begin
               if (wrap && (state_d == IDLE)) begin
                  activeDiv_d = cfg_div;
               end else begin
                  pendDiv_d = cfg_div;
                  pendVld_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      divOut_d = (state_d != IDLE) && (cnt_d < (activeDiv_d >> 1));
      tick_d   = (state_d != IDLE) && (cnt_d == '0);
   end

   // All controller state and the registered outputs. Reset is asynchronous
   // so an abort drops every output the moment rst goes low, and the ratio is
   // cleared so a fresh write is needed before the next start.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         activeDiv_q <= '0;
         pendDiv_q   <= '0;
         pendVld_q   <= 1'b0;
         cnt_q       <= '0;
         divOut_q    <= 1'b0;
         tick_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         activeDiv_q <= activeDiv_d;
         pendDiv_q   <= pendDiv_d;
         pendVld_q   <= pendVld_d;
         cnt_q       <= cnt_d;
         divOut_q    <= divOut_d;
         tick_q      <= tick_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_freq_div_ctrl
//
// Self-checking bench for freq_div_ctrl. A driver applies stimulus on the
// falling edge and steps a behavioural model of the divider. The model keeps
// a phase counter, the current ratio and a queue of staged ratios. The
// driver pushes the outputs the model predicts for the next cycle into a
// scoreboard queue. A monitor pops one entry after every rising edge and
// compares it with the DUT. Directed scenarios come first, followed by
// randomized traffic with occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_freq_div_ctrl;

   localparam int WIDTH = 8;

   logic             clock = 1'b0;
   logic             rst;
   logic             cfg_valid;
   logic [WIDTH-1:0] cfg_div;
   logic             cfg_ready;
   logic             start;
   logic             stop;
   logic             div_out;
   logic             tick;
   logic             busy;
   logic             err;

   typedef struct {
      logic divOut;
      logic tick;
      logic err;
      logic busy;
      logic ready;
   } expect_t;

   expect_t expQ[$];

   int checks = 0;
   int errors = 0;

   // Behavioural model state: whether dividing, whether a stop is pending,
   // position within the current period, current ratio, staged ratios.
   bit mActive;
   bit mDraining;
   int mPhase;
   int mN;
   int mPend[$];
   bit mErr;

   freq_div_ctrl #(.WIDTH(WIDTH)) dut (
      .clock    (clock),
      .rst      (rst),
      .cfg_valid(cfg_valid),
      .cfg_div  (cfg_div),
      .cfg_ready(cfg_ready),
      .start    (start),
      .stop     (stop),
      .div_out  (div_out),
      .tick     (tick),
      .busy     (busy),
      .err      (err)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   // Single comparison helper; every check in the bench goes through here.
   function automatic void checkOutput(string name, logic actual, logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
      end
   endfunction

   function automatic void modelReset();
      mActive   = 1'b0;
      mDraining = 1'b0;
      mPhase    = 0;
      mN        = 0;
      mPend.delete();
      mErr      = 1'b0;
   endfunction

   // One clock of the divider described in terms of periods: the period is
   // mN cycles long, the first half (rounded down) is high, staged ratios
   // take over when a period ends, and a stop ends dividing at a boundary.
   function automatic void modelStep(bit v, int d, bit s, bit p);
      bit ready;
      bit accept;
      bit wrapNow;
      bit goIdle;
      ready  = !mActive || (mPend.size() == 0);
      accept = v && ready;
      mErr   = accept && (d < 2);
      if (!mActive) begin
         if (s && !p) begin
            if (mN >= 2) begin
               mActive   = 1'b1;
               mDraining = 1'b0;
               mPhase    = 0;
            end else begin
               mErr = 1'b1;
            end
         end
         if (accept && d >= 2) mN = d;
      end else begin
         wrapNow = (mPhase == mN - 1);
         goIdle  = 1'b0;
         if (!mDraining) begin
            if (p) mDraining = 1'b1;
         end else if (s && !p) begin
            mDraining = 1'b0;
         end else if (wrapNow) begin
            goIdle = 1'b1;
         end
         mPhase = wrapNow ? 0 : mPhase + 1;
         if (wrapNow && mPend.size() > 0) mN = mPend.pop_front();
         if (accept && d >= 2) begin
            if (goIdle) mN = d;
            else mPend.push_back(d);
         end
         if (goIdle) begin
            mActive   = 1'b0;
            mDraining = 1'b0;
            mPhase    = 0;
         end
      end
   endfunction

   function automatic expect_t modelOutputs();
      expect_t e;
      e.divOut = mActive && (mPhase < mN / 2);
      e.tick   = mActive && (mPhase == 0);
      e.err    = mErr;
      e.busy   = mActive;
      e.ready  = !mActive || (mPend.size() == 0);
      return e;
   endfunction

   // Drive one cycle of inputs on the falling edge and queue the outputs the
   // model expects after the following rising edge.
   task automatic applyStimulus(bit v, int d, bit s, bit p);
      @(negedge clock);
      cfg_valid = v;
      cfg_div   = d[WIDTH-1:0];
      start     = s;
      stop      = p;
      modelStep(v, d, s, p);
      expQ.push_back(modelOutputs());
   endtask

   task automatic idleCycles(int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0);
   endtask

   // Asynchronous reset in the middle of a cycle, away from both edges. The
   // outputs must already be at their reset values while rst is still low.
   task automatic doReset();
      @(posedge clock);
      #2;
      rst       = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = '0;
      start     = 1'b0;
      stop      = 1'b0;
      #1;
      checkOutput("reset div_out", div_out, 1'b0);
      checkOutput("reset tick", tick, 1'b0);
      checkOutput("reset err", err, 1'b0);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset cfg_ready", cfg_ready, 1'b1);
      modelReset();
      #1;
      rst = 1'b1;
   endtask

   // Monitor: after every rising edge, compare the DUT with the oldest
   // prediction in the scoreboard.
   initial begin
      expect_t e;
      forever begin
         @(posedge clock);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("div_out", div_out, e.divOut);
            checkOutput("tick", tick, e.tick);
            checkOutput("err", err, e.err);
            checkOutput("busy", busy, e.busy);
            checkOutput("cfg_ready", cfg_ready, e.ready);
         end
      end
   end

   // Stimulus: directed scenarios, then randomized traffic.
   initial begin
      int r;
      int d;
      rst       = 1'b1;
      cfg_valid = 1'b0;
      cfg_div   = '0;
      start     = 1'b0;
      stop      = 1'b0;
      modelReset();
      #2;
      rst = 1'b0;
      #1;
      checkOutput("init div_out", div_out, 1'b0);
      checkOutput("init busy", busy, 1'b0);
      checkOutput("init cfg_ready", cfg_ready, 1'b1);
      #1;
      rst = 1'b1;

      $display("[TB] start with no ratio, then N=4");
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      applyStimulus(1'b1, 4, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      idleCycles(12);

      $display("[TB] N=5 with N=2 written mid-period");
      doReset();
      applyStimulus(1'b1, 5, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      idleCycles(1);
      applyStimulus(1'b1, 2, 1'b0, 1'b0);
      idleCycles(8);

      $display("[TB] N=6 stopped at cnt=2");
      doReset();
      applyStimulus(1'b1, 6, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      idleCycles(2);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      idleCycles(6);

      $display("[TB] N=3 stop then resume");
      applyStimulus(1'b1, 3, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      idleCycles(1);
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      idleCycles(6);
      applyStimulus(1'b0, 0, 1'b1, 1'b1);
      idleCycles(4);

      $display("[TB] bad ratio in idle, then N=7 written on the N=4 wrap");
      doReset();
      applyStimulus(1'b1, 4, 1'b0, 1'b0);
      applyStimulus(1'b1, 1, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      idleCycles(3);
      applyStimulus(1'b1, 7, 1'b0, 1'b0);
      idleCycles(14);
      applyStimulus(1'b1, 0, 1'b0, 1'b0);
      idleCycles(2);

      $display("[TB] async reset mid-run, start must then be rejected");
      doReset();
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      idleCycles(2);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 399);
         if (r == 0) begin
            doReset();
         end else begin
            d = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 40)
                                             : $urandom_range(0, 9);
            applyStimulus($urandom_range(0, 3) == 0, d,
                          $urandom_range(0, 5) == 0,
                          $urandom_range(0, 9) == 0);
         end
      end
      idleCycles(2);

      @(posedge clock);
      #3;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/freq_div_ctrl.md
FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of the divide ratio and period counter.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately, independent of clock.
REQ-004 cfg_valid  input  1  divide-ratio write request.
REQ-005 cfg_div  input  WIDTH  requested divide ratio N, unsigned.
REQ-006 cfg_ready  output  1  controller can accept cfg_div this cycle.
REQ-007 start  input  1  level-sampled request to begin or resume division.
REQ-008 stop  input  1  level-sampled request to end division at the next period boundary.
REQ-009 div_out  output  1  registered divided output.
REQ-010 tick  output  1  registered one-cycle pulse marking the first cycle of each div_out period.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 err  output  1  registered one-cycle pulse on a rejected ratio or a rejected start.

Function
REQ-013 States SHALL be IDLE, RUN and STOPPING; internal registers SHALL be active_div (WIDTH), pend_div (WIDTH), pend_vld (1) and cnt (WIDTH).
REQ-014 A write SHALL complete when cfg_valid=1 and cfg_ready=1 in the same cycle.
REQ-015 cfg_ready SHALL be 1 in IDLE; in RUN or STOPPING it SHALL equal !pend_vld.
REQ-016 A completed write with cfg_div<2 SHALL be dropped, SHALL leave all ratio registers unchanged, and SHALL pulse err in the next cycle.
REQ-017 A valid write in IDLE SHALL load active_div directly.
REQ-018 A valid write in RUN or STOPPING SHALL load pend_div and set pend_vld.
REQ-019 In RUN and STOPPING, cnt SHALL increment each cycle and wrap from active_div-1 to 0.
REQ-020 At the wrap, if pend_vld=1, active_div SHALL take pend_div and pend_vld SHALL clear, so the new N governs the period that starts at cnt=0.
REQ-021 A write accepted in the wrap cycle itself SHALL be applied at the following wrap.
REQ-022 div_out SHALL be 1 while cnt < floor(active_div/2) and 0 otherwise, so the period is N cycles with floor(N/2) cycles high.
REQ-023 tick SHALL be 1 exactly in cycles where cnt=0 in RUN or STOPPING.
REQ-024 IDLE -> RUN when start=1, stop=0 and active_div>=2; in the first RUN cycle cnt=0, div_out=1 (for N>=2) and tick=1.
REQ-025 start=1 with active_div<2 in IDLE SHALL be ignored and SHALL pulse err; start and stop both 1 in IDLE SHALL leave the block in IDLE with no err.
REQ-026 RUN -> STOPPING on stop=1; a repeated stop in STOPPING SHALL have no effect.
REQ-027 STOPPING -> RUN on start=1 with stop=0, with no break in the current period.
REQ-028 STOPPING -> IDLE at the wrap; then cnt=0, div_out=0, tick=0, and any pend_div SHALL be copied into active_div with pend_vld cleared.
REQ-029 In IDLE, div_out and tick SHALL be 0.

Reset
REQ-030 On rst=0: state=IDLE, active_div=0, pend_div=0, pend_vld=0, cnt=0, div_out=0, tick=0, err=0, busy=0, cfg_ready=1.
REQ-031 Reset asserted mid-period SHALL abort without completing the period; after release, a valid write is required before start succeeds.

Verification
REQ-032 After reset, start=1 -> err pulses once, busy stays 0; then write N=4 and start -> div_out 1,1,0,0 repeating, with tick on every 4th cycle.
REQ-033 Running N=5, write N=2 mid-period -> the current 5-cycle period completes (high 2, low 3), then periods become 1-high/1-low; cfg_ready is 0 until the wrap.
REQ-034 Running N=6, stop at cnt=2 -> div_out completes 3 low cycles, state goes IDLE after cnt=5, and busy falls with div_out=0.
REQ-035 Running N=3, stop then start two cycles later -> the period continues unbroken and busy never falls.
REQ-036 Write cfg_div=1 in IDLE -> err pulses and active_div is unchanged; write cfg_div=7 with cfg_valid in the wrap cycle of N=4 -> one more N=4 period runs, then N=7.
REQ-037 rst=0 asynchronously mid-RUN -> all outputs go 0 immediately and cfg_ready goes 1.
